mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_wb_reg.sv | 73 +++++++
 rtl/mem_stage_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM pipeline stage controller:
//   - mem_state_e : access FSM states (IDLE / BUSY / DONE)
//   - DATA_W, REG_W : datapath and register-index widths
//   - MEM_ADDR_BASE_DEF, MEM_ACK_TIMEOUT_DEF : parameter defaults
//   - word_addr() : base-relative, word-aligned memory address
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 4;

    localparam logic [DATA_W-1:0] MEM_ADDR_BASE_DEF   = 32'd1024;
    localparam int unsigned       MEM_ACK_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Subtract the data-memory base (wrapping modulo 2^32) and clear the
    // byte-offset bits so the memory always sees a word address.
    function automatic logic [DATA_W-1:0] word_addr(
        input logic [DATA_W-1:0] addr,
        input logic [DATA_W-1:0] base
    );
        logic [DATA_W-1:0] diff;
        diff = addr - base;
        return {diff[DATA_W-1:2], 2'b00};
    endfunction

endpackage : mem_pkg

// File: rtl/mem_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register. Loads on every clock edge where load_i is high
// (the stage is not frozen) and holds otherwise. The align flag is a pulse:
// it is only high for the cycle following the load that carried it.
// Ports:
//   clk, rst         : clock, synchronous active-low reset
//   load_i           : load enable (inverse of the stage freeze)
//   wb_en_i, mem_r_en_i, alu_res_i, mem_res_i, dest_i, align_i : next values
//   wb_en_o, mem_r_en_o, alu_res_o, mem_res_o, dest_o, align_o : registered
// -----------------------------------------------------------------------------
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              wb_en_i,
    input  logic              mem_r_en_i,
    input  logic [DATA_W-1:0] alu_res_i,
    input  logic [DATA_W-1:0] mem_res_i,
    input  logic [REG_W-1:0]  dest_i,
    input  logic              align_i,
    output logic              wb_en_o,
    output logic              mem_r_en_o,
    output logic [DATA_W-1:0] alu_res_o,
    output logic [DATA_W-1:0] mem_res_o,
    output logic [REG_W-1:0]  dest_o,
    output logic              align_o
);

    logic              wb_en_q;
    logic              mem_r_en_q;
    logic [DATA_W-1:0] alu_res_q;
    logic [DATA_W-1:0] mem_res_q;
    logic [REG_W-1:0]  dest_q;
    logic              align_q;

    // MEM/WB pipeline register with load/hold and reset-to-zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_res_q  <= 32'h0000_0000;
            mem_res_q  <= 32'h0000_0000;
            dest_q     <= 4'h0;
            align_q    <= 1'b0;
        end else if (load_i) begin
            wb_en_q    <= wb_en_i;
            mem_r_en_q <= mem_r_en_i;
            alu_res_q  <= alu_res_i;
            mem_res_q  <= mem_res_i;
            dest_q     <= dest_i;
            align_q    <= align_i;
        end else begin
            // Hold the instruction, but never stretch the align pulse.
            wb_en_q    <= wb_en_q;
            mem_r_en_q <= mem_r_en_q;
            alu_res_q  <= alu_res_q;
            mem_res_q  <= mem_res_q;
            dest_q     <= dest_q;
            align_q    <= 1'b0;
        end
    end

    assign wb_en_o    = wb_en_q;
    assign mem_r_en_o = mem_r_en_q;
    assign alu_res_o  = alu_res_q;
    assign mem_res_o  = mem_res_q;
    assign dest_o     = dest_q;
    assign align_o    = align_q;

endmodule : mem_wb_reg

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// MEM pipeline stage: runs a request/ack handshake to data memory for loads
// and stores, freezes the upstream pipeline while the access is in flight,
// aborts after ACK_TIMEOUT BUSY cycles without ack, and feeds the MEM/WB
// register (mem_wb_reg).
//
// Optional feature macro: MEM_ALIGN_CHK_EN
//   defined   : accesses with ALU_RES_MEM[1:0] != 0 are not issued; they pass
//               straight through with WB_EN_WB=0 and a one-cycle align_err.
//   undefined : low address bits are ignored and align_err is always 0.
//
// Parameters: ADDR_BASE (data-memory base), ACK_TIMEOUT (BUSY cycle limit)
// Ports:
//   clk, rst                              : clock, sync active-low reset
//   WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM : control from EXE/MEM
//   ALU_RES_MEM, VAL_RM_MEM, DEST_MEM     : address/result, store data, dest
//   mem_req, mem_we, mem_addr, mem_wdata  : memory request side
//   mem_rdata, mem_ack                    : memory response side
//   freeze                                : upstream stall
//   WB_EN_WB, MEM_R_EN_WB, ALU_RES_WB, MEM_RES_WB, DEST_WB : MEM/WB outputs
//   timeout_err, align_err                : error pulses
// -----------------------------------------------------------------------------
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter logic [DATA_W-1:0] ADDR_BASE   = MEM_ADDR_BASE_DEF,
    parameter int unsigned       ACK_TIMEOUT = MEM_ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN_MEM,
    input  logic              MEM_R_EN_MEM,
    input  logic              MEM_W_EN_MEM,
    input  logic [DATA_W-1:0] ALU_RES_MEM,
    input  logic [DATA_W-1:0] VAL_RM_MEM,
    input  logic [REG_W-1:0]  DEST_MEM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              freeze,
    output logic              WB_EN_WB,
    output logic              MEM_R_EN_WB,
    output logic [DATA_W-1:0] ALU_RES_WB,
    output logic [DATA_W-1:0] MEM_RES_WB,
    output logic [REG_W-1:0]  DEST_WB,
    output logic              timeout_err,
    output logic              align_err
);

    // The counter only has to reach ACK_TIMEOUT-1.
    localparam int unsigned       CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              to_q, to_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;

    logic mem_acc_s;
    logic misalign_s;
    logic start_s;
    logic wb_load_s;

    assign mem_acc_s = MEM_R_EN_MEM | MEM_W_EN_MEM;

`ifdef MEM_ALIGN_CHK_EN
    assign misalign_s = mem_acc_s & (ALU_RES_MEM[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // A misaligned access is never issued, so it neither starts nor stalls.
    assign start_s = mem_acc_s & ~misalign_s;

    // DONE releases the stall for one cycle so the EXE/MEM and MEM/WB
    // registers advance past the finished access.
    assign freeze    = start_s & (state_q != ST_DONE);
    assign wb_load_s = ~freeze;

    // Access FSM next-state, timeout counter and request/response capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_BUSY;
                    cnt_d   = {CNT_W{1'b0}};
                    // Latch the request so it stays stable through BUSY.
                    addr_d  = word_addr(ALU_RES_MEM, ADDR_BASE);
                    wdata_d = VAL_RM_MEM;
                    we_d    = MEM_W_EN_MEM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    to_d    = 1'b1;
                    rdata_d = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Access FSM state and request/response registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            to_q    <= 1'b0;
            rdata_q <= 32'h0000_0000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign mem_req     = (state_q == ST_BUSY);
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign timeout_err = to_q;

    // to_q is high exactly in the DONE cycle of an aborted access, which is
    // the cycle the MEM/WB register loads it.
    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .load_i     (wb_load_s),
        .wb_en_i    (WB_EN_MEM & ~to_q & ~misalign_s),
        .mem_r_en_i (MEM_R_EN_MEM),
        .alu_res_i  (ALU_RES_MEM),
        .mem_res_i  ((MEM_R_EN_MEM & ~misalign_s) ? rdata_q : 32'h0000_0000),
        .dest_i     (DEST_MEM),
        .align_i    (misalign_s),
        .wb_en_o    (WB_EN_WB),
        .mem_r_en_o (MEM_R_EN_WB),
        .alu_res_o  (ALU_RES_WB),
        .mem_res_o  (MEM_RES_WB),
        .dest_o     (DEST_WB),
        .align_o    (align_err)
    );

endmodule : mem_stage_ctrl

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Scoreboard bench for mem_stage_ctrl (ACK_TIMEOUT=4, ADDR_BASE=1024).
// The bench acts as the surrounding pipeline and the memory: it holds each
// instruction while freeze is high, answers mem_req with mem_ack after a
// chosen number of BUSY cycles, and compares the MEM/WB outputs after the
// load edge against expected entries queued when the instruction was driven.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;
    import mem_pkg::*;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam logic [31:0] TB_BASE    = 32'd1024;
`ifdef MEM_ALIGN_CHK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM;
    logic [31:0] ALU_RES_MEM, VAL_RM_MEM;
    logic [3:0]  DEST_MEM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        freeze;
    logic        WB_EN_WB, MEM_R_EN_WB;
    logic [31:0] ALU_RES_WB, MEM_RES_WB;
    logic [3:0]  DEST_WB;
    logic        timeout_err, align_err;

    mem_stage_ctrl #(.ADDR_BASE(TB_BASE), .ACK_TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM), .MEM_W_EN_MEM(MEM_W_EN_MEM),
        .ALU_RES_MEM(ALU_RES_MEM), .VAL_RM_MEM(VAL_RM_MEM), .DEST_MEM(DEST_MEM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze),
        .WB_EN_WB(WB_EN_WB), .MEM_R_EN_WB(MEM_R_EN_WB), .ALU_RES_WB(ALU_RES_WB),
        .MEM_RES_WB(MEM_RES_WB), .DEST_WB(DEST_WB),
        .timeout_err(timeout_err), .align_err(align_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb_en;
        logic        mem_r;
        logic [31:0] alu;
        logic [31:0] memres;
        logic [3:0]  dest;
        logic        align;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int      n_chk  = 0;
    int      n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Present one instruction, act as memory until the stage releases it,
    // then compare the MEM/WB outputs with the queued expectation.
    // ack_at = BUSY cycle (1-based) in which mem_ack is raised, 0 = never.
    task automatic run_instr(input logic wb_en, input logic rd, input logic wr,
                             input logic [31:0] alu, input logic [31:0] val,
                             input logic [3:0] dest, input int ack_at,
                             input logic [31:0] rdata);
        wb_exp_t     e;
        wb_exp_t     got;
        int          stall;
        int          busy;
        int          exp_stall;
        bit          done;
        logic        acc, mis, to;
        logic [31:0] exp_addr;

        acc       = rd | wr;
        mis       = ALIGN_ON && acc && (alu[1:0] != 2'b00);
        to        = acc && !mis && (ack_at == 0);
        exp_stall = (!acc || mis) ? 0 : 1 + ((ack_at == 0) ? int'(TB_TIMEOUT) : ack_at);
        exp_addr  = (alu - TB_BASE) & 32'hFFFF_FFFC;

        e.wb_en  = wb_en & ~to & ~mis;
        e.mem_r  = rd;
        e.alu    = alu;
        e.memres = (rd && !mis && !to) ? rdata : 32'h0;
        e.dest   = dest;
        e.align  = mis;
        sb_q.push_back(e);

        WB_EN_MEM    = wb_en;
        MEM_R_EN_MEM = rd;
        MEM_W_EN_MEM = wr;
        ALU_RES_MEM  = alu;
        VAL_RM_MEM   = val;
        DEST_MEM     = dest;

        stall = 0;
        busy  = 0;
        done  = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (freeze == 1'b0) begin
                mem_ack = 1'b0;
                check_val("timeout_err", timeout_err, to);
                check_val("mem_req_released", mem_req, 1'b0);
                done = 1'b1;
            end else begin
                stall++;
                if (mem_req == 1'b1) begin
                    busy++;
                    check_val("mem_addr", mem_addr, exp_addr);
                    check_val("mem_we", mem_we, wr);
                    if (wr) check_val("mem_wdata", mem_wdata, val);
                    mem_ack   = (busy == ack_at);
                    mem_rdata = (busy == ack_at) ? rdata : ~rdata;
                end else begin
                    mem_ack = 1'b0;
                end
            end
        end
        if (!done) check_val("cycle_bound", 32'd1, 32'd0);
        check_val("stall_cycles", stall, exp_stall);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            check_val("WB_EN_WB", WB_EN_WB, got.wb_en);
            check_val("MEM_R_EN_WB", MEM_R_EN_WB, got.mem_r);
            check_val("ALU_RES_WB", ALU_RES_WB, got.alu);
            check_val("MEM_RES_WB", MEM_RES_WB, got.memres);
            check_val("DEST_WB", DEST_WB, got.dest);
            check_val("align_err", align_err, got.align);
        end
    endtask

    // Reset while a load is in BUSY, with a stray ack one cycle later.
    task automatic reset_in_busy();
        bit seen;
        WB_EN_MEM    = 1'b1;
        MEM_R_EN_MEM = 1'b1;
        MEM_W_EN_MEM = 1'b0;
        ALU_RES_MEM  = 32'd1060;
        VAL_RM_MEM   = 32'h0;
        DEST_MEM     = 4'd9;
        mem_ack      = 1'b0;
        seen         = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            seen = (mem_req == 1'b1);
        end
        check_val("rst_busy_reached", seen, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("rst_mem_req", mem_req, 1'b0);
        check_val("rst_freeze_follows_load", freeze, 1'b1);
        check_val("rst_WB_EN_WB", WB_EN_WB, 1'b0);
        check_val("rst_ALU_RES_WB", ALU_RES_WB, 32'h0);
        check_val("rst_MEM_RES_WB", MEM_RES_WB, 32'h0);
        check_val("rst_DEST_WB", DEST_WB, 4'h0);
        check_val("rst_timeout_err", timeout_err, 1'b0);
        rst          = 1'b1;
        MEM_R_EN_MEM = 1'b0;
        WB_EN_MEM    = 1'b0;
        mem_ack      = 1'b1;
        mem_rdata    = 32'hFEED_FACE;
        @(negedge clk);
        check_val("late_ack_mem_req", mem_req, 1'b0);
        check_val("late_ack_freeze", freeze, 1'b0);
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        WB_EN_MEM    = 1'b0;
        MEM_R_EN_MEM = 1'b0;
        MEM_W_EN_MEM = 1'b0;
        ALU_RES_MEM  = 32'h0;
        VAL_RM_MEM   = 32'h0;
        DEST_MEM     = 4'h0;
        mem_rdata    = 32'h0;
        mem_ack      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_WB_EN_WB", WB_EN_WB, 1'b0);
        check_val("reset_MEM_RES_WB", MEM_RES_WB, 32'h0);
        check_val("reset_mem_req", mem_req, 1'b0);
        check_val("reset_freeze", freeze, 1'b0);
        check_val("reset_timeout_err", timeout_err, 1'b0);
        check_val("reset_align_err", align_err, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // wb_en rd wr alu val dest ack_at rdata
        run_instr(1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0,          4'd3, 0, 32'h0);          // ADD
        run_instr(1'b1, 1'b1, 1'b0, 32'd1028,      32'h0,          4'd5, 3, 32'hDEAD_BEEF);  // load, ack BUSY #3
        run_instr(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0,          4'd6, 0, 32'h0);          // ADD
        run_instr(1'b0, 1'b0, 1'b1, 32'd1032,      32'h1234_5678,  4'd0, 1, 32'h0);          // store, ack BUSY #1
        run_instr(1'b1, 1'b1, 1'b0, 32'd1124,      32'h0,          4'd7, 2, 32'hA5A5_5A5A);  // back-to-back load
        run_instr(1'b1, 1'b1, 1'b0, 32'd8,         32'h0,          4'd2, 1, 32'h0BAD_CAFE);  // address below base wraps
        run_instr(1'b1, 1'b1, 1'b0, 32'd1040,      32'h0,          4'd8, 0, 32'h1111_2222);  // timeout
        run_instr(1'b1, 1'b0, 1'b0, 32'h0000_0099, 32'h0,          4'd1, 0, 32'h0);          // ADD after abort
        run_instr(1'b1, 1'b1, 1'b0, 32'd1026,      32'h0,          4'd4, 1, 32'h3333_4444);  // misaligned load
        run_instr(1'b1, 1'b0, 1'b0, 32'h0000_00AA, 32'h0,          4'd10, 0, 32'h0);         // align pulse clears
        run_instr(1'b1, 1'b0, 1'b0, 32'h0000_00BB, 32'h0,          4'd11, 0, 32'h0);         // WB holds non-zero values
        reset_in_busy();
        run_instr(1'b1, 1'b1, 1'b0, 32'd1200,      32'h0,          4'd12, 2, 32'h5555_AAAA); // recovery after reset

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mem_stage_ctrl
